ub_read_sequencer: RTL and testbench
====================================

UB_READ_SEQUENCER -- requirements
Module: ub_read_sequencer

Interface
REQ-001 SHALL have ports: clk_i  input  1  sole clock; all logic on rising edge.
REQ-002 SHALL have ports: rst_i  input  1  reset, synchronous, active-high.
REQ-003 SHALL have ports: start_i  input  1  request to stream a tile; sampled only in IDLE.
REQ-004 SHALL have ports: base_addr_i  input  12  first unified-buffer row address.
REQ-005 SHALL have ports: num_rows_i  input  12  rows to stream (0 legal).
REQ-006 SHALL have ports: ub_read_o  output  1  unified-buffer read enable.
REQ-007 SHALL have ports: ub_addr_rd_o  output  12  unified-buffer read address.
REQ-008 SHALL have ports: ub_data_i  input  [ACT_WIDTH:0] x MUL_SIZE  unified-buffer read data, valid the cycle after ub_read_o.
REQ-009 SHALL have ports: act_o  output  [ACT_WIDTH:0] x MUL_SIZE  skewed activations to systolic array.
REQ-010 SHALL have ports: act_valid_o  output  MUL_SIZE  per-lane valid.
REQ-011 SHALL have ports: busy_o  output  1  tile in progress.
REQ-012 SHALL have ports: done_o  output  1  one-cycle completion pulse.
REQ-013 SHALL have ports: err_o  output  1  one-cycle rejection pulse (see Configuration).

Function
REQ-014 SHALL implement FSM states IDLE, ISSUE, DRAIN; IDLE->ISSUE on accepted start_i with num_rows_i>0; ISSUE->DRAIN after num_rows_i reads; DRAIN->IDLE after MUL_SIZE+1 cycles.
REQ-015 SHALL latch base_addr_i/num_rows_i on accepted start (cycle T); later input changes have no effect on the tile.
REQ-016 SHALL drive ub_read_o=1, ub_addr_rd_o=base+r (mod 4096) in cycle T+1+r, r=0..n-1; ub_read_o=0 and ub_addr_rd_o=0 otherwise.
REQ-017 SHALL register ub_data_i once, then delay lane k by k further cycles: act_o[k] carries row r lane k in cycle T+3+r+k, with act_valid_o[k]=1.
REQ-018 SHALL drive act_o[k]=0 and act_valid_o[k]=0 in every cycle a lane carries no valid row.
REQ-019 SHALL assert busy_o in cycles T+1 through T+1+n+MUL_SIZE; pulse done_o in cycle T+2+n+MUL_SIZE with busy_o=0 and FSM in IDLE.
REQ-020 SHALL accept a new start_i in the done_o cycle (back-to-back tiles, no gap in ub_read_o beyond the drain).
REQ-021 SHALL ignore start_i while busy_o=1.
REQ-022 SHALL, for num_rows_i=0, issue no reads, keep busy_o=0, pulse done_o in T+1.

Reset
REQ-023 SHALL, on rst_i high at an edge, force IDLE, clear counters and all skew registers; all outputs 0 the following cycle.
REQ-024 SHALL abort any tile on mid-operation reset with no done_o and no residual valid lanes.

Configuration
REQ-025 SHALL, with UB_SEQ_BOUNDS_CHECK_EN defined, reject a start where base_addr_i+num_rows_i>4096: no reads, err_o pulse in T+1, no done_o, stay IDLE.
REQ-026 SHALL, without UB_SEQ_BOUNDS_CHECK_EN, wrap addresses mod 4096 and tie err_o to 0.

Structure
REQ-027 SHALL take ACT_WIDTH, MUL_SIZE from tpu_package; SHALL add UB_ADDR_WIDTH=12, UB_DEPTH=4096 and typedef act_t (logic [ACT_WIDTH:0]) to tpu_package.
REQ-028 SHALL instantiate one sub-module skew_line (parameter DEPTH, data+valid delay chain, sync reset) per lane with DEPTH=k.

Verification
REQ-029 SHALL cover: start base=0x010, n=4 -> reads 0x010..0x013 in T+1..T+4; lane 0 valid T+3..T+6; lane MUL_SIZE-1 valid T+2+MUL_SIZE..T+5+MUL_SIZE; done_o at T+6+MUL_SIZE.
REQ-030 SHALL cover: base=0xFFE, n=4 without macro -> addresses 0xFFE,0xFFF,0x000,0x001; with macro -> err_o at T+1, no reads.
REQ-031 SHALL cover: n=0 -> done_o at T+1, ub_read_o never high, busy_o never high.
REQ-032 SHALL cover: start_i held high through tile of n=3 -> single tile until done cycle, second tile starts reads at done cycle+1.
REQ-033 SHALL cover: rst_i asserted at T+3 of n=8 tile -> next cycle all outputs 0, no done_o, new start accepted afterwards.

Source files
------------

// File: rtl/tpu_package.sv
// Shared TPU parameters and types used by the unified-buffer read path.
package tpu_package;

  localparam int ACT_WIDTH     = 7;
  localparam int MUL_SIZE      = 4;
  localparam int UB_ADDR_WIDTH = 12;
  localparam int UB_DEPTH      = 4096;

  typedef logic [ACT_WIDTH:0] act_t;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    DRAIN
  } seq_state_t;

endpackage

// File: rtl/skew_line.sv
// Per-lane delay line: DEPTH register stages of activation data plus valid.
// Data is zeroed whenever valid is low, so an idle lane always shows zero.
module skew_line
  import tpu_package::*;
#(
  parameter int DEPTH = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [ACT_WIDTH:0] data,
  input  logic               valid,
  output logic [ACT_WIDTH:0] data_dly,
  output logic               valid_dly
);

  generate
    if (DEPTH == 0) begin : g_pass
      assign data_dly  = valid ? data : '0;
      assign valid_dly = valid;
    end else begin : g_chain
      act_t data_sr  [DEPTH];
      logic valid_sr [DEPTH];

      always_ff @(posedge clk) begin
        if (rst) begin
          for (int i = 0; i < DEPTH; i++) begin
            data_sr[i]  <= '0;
            valid_sr[i] <= 1'b0;
          end
        end else begin
          data_sr[0]  <= valid ? data : '0;
          valid_sr[0] <= valid;
          for (int i = 1; i < DEPTH; i++) begin
            data_sr[i]  <= data_sr[i-1];
            valid_sr[i] <= valid_sr[i-1];
          end
        end
      end

      assign data_dly  = data_sr[DEPTH-1];
      assign valid_dly = valid_sr[DEPTH-1];
    end
  endgenerate

endmodule

// File: rtl/ub_read_sequencer.sv
// Streams a tile of unified-buffer rows into the systolic array with per-lane skew.
// Optional macro UB_SEQ_BOUNDS_CHECK_EN rejects tiles that would run past the buffer end.
module ub_read_sequencer
  import tpu_package::*;
(
  input  logic                              clk_i,
  input  logic                              rst_i,
  input  logic                              start_i,
  input  logic [UB_ADDR_WIDTH-1:0]          base_addr_i,
  input  logic [UB_ADDR_WIDTH-1:0]          num_rows_i,
  output logic                              ub_read_o,
  output logic [UB_ADDR_WIDTH-1:0]          ub_addr_rd_o,
  input  logic [MUL_SIZE-1:0][ACT_WIDTH:0]  ub_data_i,
  output logic [MUL_SIZE-1:0][ACT_WIDTH:0]  act_o,
  output logic [MUL_SIZE-1:0]               act_valid_o,
  output logic                              busy_o,
  output logic                              done_o,
  output logic                              err_o
);

  seq_state_t state, state_next;

  logic [UB_ADDR_WIDTH-1:0] base_q, rows_q, row_cnt;
  logic [7:0]               drain_cnt;
  logic                     accept, reject, last_row, drain_end;
  logic                     done_q, rd_pend, cap_valid;
  logic [MUL_SIZE-1:0][ACT_WIDTH:0] cap_data;

`ifdef UB_SEQ_BOUNDS_CHECK_EN
  logic err_q;

  assign reject = ({1'b0, base_addr_i} + {1'b0, num_rows_i}) > 13'(UB_DEPTH);

  always_ff @(posedge clk_i) begin
    if (rst_i) err_q <= 1'b0;
    else       err_q <= (state == IDLE) && start_i && reject;
  end

  assign err_o = err_q;
`else
  assign reject = 1'b0;
  assign err_o  = 1'b0;
`endif

  assign accept    = (state == IDLE) && start_i && !reject;
  assign last_row  = row_cnt == (rows_q - 12'd1);
  assign drain_end = drain_cnt == 8'(MUL_SIZE);

  always_ff @(posedge clk_i) begin
    if (rst_i) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (accept && num_rows_i != '0) state_next = ISSUE;
      ISSUE:   if (last_row)                   state_next = DRAIN;
      DRAIN:   if (drain_end)                  state_next = IDLE;
      default:                                 state_next = IDLE;
    endcase
  end

  always_comb begin
    ub_read_o    = 1'b0;
    ub_addr_rd_o = '0;
    busy_o       = state != IDLE;
    if (state == ISSUE) begin
      ub_read_o    = 1'b1;
      ub_addr_rd_o = base_q + row_cnt;
    end
  end

  // Drain lasts MUL_SIZE+1 cycles so the last row clears the deepest lane.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      base_q    <= '0;
      rows_q    <= '0;
      row_cnt   <= '0;
      drain_cnt <= '0;
      done_q    <= 1'b0;
    end else begin
      done_q <= ((state == DRAIN) && drain_end) || (accept && num_rows_i == '0);
      if (accept) begin
        base_q    <= base_addr_i;
        rows_q    <= num_rows_i;
        row_cnt   <= '0;
        drain_cnt <= '0;
      end else if (state == ISSUE) begin
        row_cnt <= row_cnt + 12'd1;
      end else if (state == DRAIN) begin
        drain_cnt <= drain_cnt + 8'd1;
      end
    end
  end

  assign done_o = done_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rd_pend   <= 1'b0;
      cap_valid <= 1'b0;
      cap_data  <= '0;
    end else begin
      rd_pend   <= ub_read_o;
      cap_valid <= rd_pend;
      cap_data  <= rd_pend ? ub_data_i : '0;
    end
  end

  for (genvar k = 0; k < MUL_SIZE; k++) begin : g_lane
    skew_line #(.DEPTH(k)) u_skew (
      .clk       (clk_i),
      .rst       (rst_i),
      .data      (cap_data[k]),
      .valid     (cap_valid),
      .data_dly  (act_o[k]),
      .valid_dly (act_valid_o[k])
    );
  end

endmodule

// File: tb/tb_ub_read_sequencer.sv
// Self-checking bench for ub_read_sequencer: vector table, corner sequences and
// random tiles, all checked against a cycle-indexed tile model.
module tb_ub_read_sequencer;
  import tpu_package::*;

  localparam int NC = 8192;

  logic clk_i = 1'b0;
  logic rst_i, start_i;
  logic [11:0] base_addr_i, num_rows_i;
  logic ub_read_o;
  logic [11:0] ub_addr_rd_o;
  logic [MUL_SIZE-1:0][ACT_WIDTH:0] ub_data_i, act_o;
  logic [MUL_SIZE-1:0] act_valid_o;
  logic busy_o, done_o, err_o;

  ub_read_sequencer dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .start_i      (start_i),
    .base_addr_i  (base_addr_i),
    .num_rows_i   (num_rows_i),
    .ub_read_o    (ub_read_o),
    .ub_addr_rd_o (ub_addr_rd_o),
    .ub_data_i    (ub_data_i),
    .act_o        (act_o),
    .act_valid_o  (act_valid_o),
    .busy_o       (busy_o),
    .done_o       (done_o),
    .err_o        (err_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct packed {
    logic                             busy;
    logic                             done;
    logic                             err;
    logic                             rd;
    logic [11:0]                      addr;
    logic [MUL_SIZE-1:0]              valid;
    logic [MUL_SIZE-1:0][ACT_WIDTH:0] act;
  } obs_t;

  typedef struct {
    logic [11:0] base;
    logic [11:0] rows;
    int          reads;
    logic [11:0] first;
    logic [11:0] last;
    int          done_lat;
    int          err_lat;
  } vec_t;

  obs_t exp_q [NC];
  bit   chk   [NC];
  obs_t seen;
  int   cyc, next_ok, n_cmp, n_bad;
  logic last_rd;
  logic [11:0] last_addr;

  function automatic act_t mem_val(input logic [11:0] a, input int k);
    return act_t'(int'(a) * 3 + k * 37 + 11);
  endfunction

  // Tile model: fills expected outputs for a start accepted in cycle t and
  // returns the first cycle in which another start may be accepted.
  function automatic int schedule(input int t, input logic [11:0] b, input logic [11:0] n);
    int rows = int'(n);
    int a;
`ifdef UB_SEQ_BOUNDS_CHECK_EN
    if (int'(b) + rows > UB_DEPTH) begin
      exp_q[t+1].err = 1'b1;
      return t + 1;
    end
`endif
    if (rows == 0) begin
      exp_q[t+1].done = 1'b1;
      return t + 1;
    end
    for (int r = 0; r < rows; r++) begin
      a = (int'(b) + r) % UB_DEPTH;
      exp_q[t+1+r].rd   = 1'b1;
      exp_q[t+1+r].addr = 12'(a);
      for (int k = 0; k < MUL_SIZE; k++) begin
        exp_q[t+3+r+k].valid[k] = 1'b1;
        exp_q[t+3+r+k].act[k]   = mem_val(12'(a), k);
      end
    end
    for (int c = t + 1; c <= t + 1 + rows + MUL_SIZE; c++) exp_q[c].busy = 1'b1;
    exp_q[t+2+rows+MUL_SIZE].done = 1'b1;
    return t + 2 + rows + MUL_SIZE;
  endfunction

  task automatic check_output(input string name, input int act, input int req);
    n_cmp++;
    if (act != req) begin
      n_bad++;
      $display("[TB] FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // One clock cycle: compare outputs, feed buffer data, drive inputs, update model.
  task automatic apply_stimulus(input logic s, input logic [11:0] b, input logic [11:0] n,
                                input logic r);
    @(negedge clk_i);
    cyc++;
    if (cyc >= NC - 300) begin
      n_bad++;
      $display("[TB] FAIL cycle_budget actual=%0d required<%0d", cyc, NC - 300);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $fatal(1, "[TB] cycle budget exhausted");
    end
    seen = {busy_o, done_o, err_o, ub_read_o, ub_addr_rd_o, act_valid_o, act_o};
    if (chk[cyc]) begin
      n_cmp++;
      if (seen !== exp_q[cyc]) begin
        n_bad++;
        $display("[TB] FAIL cycle_%0d outputs actual=%h required=%h", cyc, seen, exp_q[cyc]);
      end
    end
    for (int k = 0; k < MUL_SIZE; k++)
      ub_data_i[k] = (last_rd === 1'b1) ? mem_val(last_addr, k) : act_t'($urandom);
    last_rd   = ub_read_o;
    last_addr = ub_addr_rd_o;
    rst_i       = r;
    start_i     = s;
    base_addr_i = b;
    num_rows_i  = n;
    if (r) begin
      for (int c = cyc + 1; c < NC; c++) begin
        exp_q[c] = '0;
        chk[c]   = 1'b1;
      end
      next_ok = cyc + 1;
    end else if (s && cyc >= next_ok) begin
      next_ok = schedule(cyc, b, n);
    end
  endtask

  task automatic run_vec(input vec_t v);
    int t, reads, dl, el;
    logic [11:0] fa, la;
    reads = 0; dl = 0; el = 0; fa = '0; la = '0;
    apply_stimulus(1'b1, v.base, v.rows, 1'b0);
    t = cyc;
    for (int i = 0; i < int'(v.rows) + 12; i++) begin
      apply_stimulus(1'b0, 12'h0, 12'h0, 1'b0);
      if (seen.rd === 1'b1) begin
        if (reads == 0) fa = seen.addr;
        la = seen.addr;
        reads++;
      end
      if (seen.done === 1'b1 && dl == 0) dl = cyc - t;
      if (seen.err === 1'b1 && el == 0) el = cyc - t;
    end
    check_output("vec_reads", reads, v.reads);
    check_output("vec_first_addr", int'(fa), int'(v.first));
    check_output("vec_last_addr", int'(la), int'(v.last));
    check_output("vec_done_latency", dl, v.done_lat);
    check_output("vec_err_latency", el, v.err_lat);
  endtask

  vec_t vecs [7];

  initial begin
    int t, cnt, cnt2, first_b;
    logic s, r;
    logic [11:0] b, n;

    rst_i = 1'b1; start_i = 1'b0; base_addr_i = '0; num_rows_i = '0; ub_data_i = '0;
    cyc = 0; next_ok = 0; n_cmp = 0; n_bad = 0; last_rd = 1'b0; last_addr = '0;
    for (int c = 0; c < NC; c++) begin
      exp_q[c] = '0;
      chk[c]   = 1'b0;
    end

    vecs[0] = '{12'h010, 12'd4,   4,   12'h010, 12'h013, 10,  0};
    vecs[1] = '{12'h000, 12'd1,   1,   12'h000, 12'h000, 7,   0};
    vecs[2] = '{12'h123, 12'd0,   0,   12'h000, 12'h000, 1,   0};
    vecs[3] = '{12'h7FF, 12'd16,  16,  12'h7FF, 12'h80E, 22,  0};
    vecs[4] = '{12'hF00, 12'd256, 256, 12'hF00, 12'hFFF, 262, 0};
`ifdef UB_SEQ_BOUNDS_CHECK_EN
    vecs[5] = '{12'hFFE, 12'd4,   0,   12'h000, 12'h000, 0,   1};
    vecs[6] = '{12'hF01, 12'd256, 0,   12'h000, 12'h000, 0,   1};
`else
    vecs[5] = '{12'hFFE, 12'd4,   4,   12'hFFE, 12'h001, 10,  0};
    vecs[6] = '{12'hF01, 12'd256, 256, 12'hF01, 12'h000, 262, 0};
`endif

    apply_stimulus(1'b0, 12'h0, 12'h0, 1'b1);
    apply_stimulus(1'b0, 12'h0, 12'h0, 1'b1);
    apply_stimulus(1'b0, 12'h0, 12'h0, 1'b0);

    for (int i = 0; i < 7; i++) run_vec(vecs[i]);

    // Start held high through a 3-row tile; base changes mid-tile.
    cnt = 0; cnt2 = 0; first_b = 0;
    apply_stimulus(1'b1, 12'h200, 12'd3, 1'b0);
    t = cyc;
    for (int i = 1; i < 22; i++) begin
      apply_stimulus((i < 10) ? 1'b1 : 1'b0, (i < 2) ? 12'h200 : 12'h300, 12'd3, 1'b0);
      if (seen.rd === 1'b1) cnt++;
      if (seen.done === 1'b1) cnt2++;
      if (seen.rd === 1'b1 && seen.addr == 12'h300 && first_b == 0) first_b = cyc - t;
    end
    check_output("b2b_reads", cnt, 6);
    check_output("b2b_dones", cnt2, 2);
    check_output("b2b_second_read_cycle", first_b, 10);

    // Reset three cycles into an 8-row tile.
    apply_stimulus(1'b1, 12'h040, 12'd8, 1'b0);
    apply_stimulus(1'b0, 12'h0, 12'h0, 1'b0);
    apply_stimulus(1'b0, 12'h0, 12'h0, 1'b0);
    apply_stimulus(1'b0, 12'h0, 12'h0, 1'b1);
    cnt = 0; cnt2 = 0;
    for (int i = 0; i < 20; i++) begin
      apply_stimulus(1'b0, 12'h0, 12'h0, 1'b0);
      if (seen.done === 1'b1) cnt++;
      if (seen.busy !== 1'b0 || seen.rd !== 1'b0 || seen.valid !== '0) cnt2++;
    end
    check_output("abort_dones", cnt, 0);
    check_output("abort_active_cycles", cnt2, 0);
    apply_stimulus(1'b1, 12'h080, 12'd2, 1'b0);
    t = cyc; cnt = 0;
    for (int i = 0; i < 12; i++) begin
      apply_stimulus(1'b0, 12'h0, 12'h0, 1'b0);
      if (seen.done === 1'b1 && cnt == 0) cnt = cyc - t;
    end
    check_output("restart_done_latency", cnt, 8);

    for (int i = 0; i < 3000; i++) begin
      s = ($urandom_range(0, 2) == 0);
      r = ($urandom_range(0, 149) == 0);
      b = ($urandom_range(0, 1) == 0) ? 12'($urandom) : 12'(12'hFF0 + $urandom_range(0, 15));
      case ($urandom_range(0, 3))
        0:       n = 12'd0;
        1:       n = 12'd1;
        2:       n = 12'($urandom_range(2, 20));
        default: n = 12'($urandom_range(1, 6));
      endcase
      apply_stimulus(s, b, n, r);
    end
    for (int i = 0; i < 40; i++) apply_stimulus(1'b0, 12'h0, 12'h0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
